// File: rtl/ddr_game_sequencer_if.sv
// rtl/ddr_game_sequencer_if.sv - player/level/display signal bundle for the game sequencer
interface ddr_game_sequencer_if #(
   parameter int SCORE_W = 8
);
   logic               tick;
   logic               start_btn;
   logic [3:0]         btn;
   logic [3:0]         tgt;
   logic               level_done;
   logic [1:0]         level_sel;
   logic               level_start;
   logic [SCORE_W-1:0] score;
   logic [7:0]         misses;
   logic               hit_pulse;
   logic               miss_pulse;
   logic               game_over;
   logic               game_won;

   modport master (
      output tick, start_btn, btn, tgt, level_done,
      input  level_sel, level_start, score, misses, hit_pulse, miss_pulse, game_over, game_won
   );

   modport slave (
      input  tick, start_btn, btn, tgt, level_done,
      output level_sel, level_start, score, misses, hit_pulse, miss_pulse, game_over, game_won
   );
endinterface

// File: rtl/ddr_game_sequencer.sv
// rtl/ddr_game_sequencer.sv - level launch, hit-window judging and scoring for the arrow game
module ddr_game_sequencer #(
   parameter int NUM_LEVELS = 3,
   parameter int HIT_WINDOW = 250,
   parameter int PASS_SCORE = 16,
   parameter int SCORE_W    = 8
) (
   input logic                 clk,
   input logic                 rst,
   ddr_game_sequencer_if.slave bus
);
   localparam int CNT_W = $clog2(HIT_WINDOW + 1);

   typedef enum logic [2:0] {IDLE, LAUNCH, PLAY, JUDGE, NEXT, WON, LOST} state_t;

   state_t             state;
   logic               start_q;
   logic [3:0]         btn_q;
   logic [3:0]         tgt_q;
   logic [3:0]         pending;
   logic               win_open;
   logic [CNT_W-1:0]   win_cnt;
   logic [SCORE_W-1:0] level_hits;

   logic               start_edge;
   logic [3:0]         press;
   logic               tgt_onehot;
   logic               new_tgt;
   logic               hit_now;
   logic               miss_now;
   logic               open_mid;
   logic               open_end;

   // Judging order: press, expiry, target replacement, level end; each step sees the window left by the previous one.
   always_comb begin
      start_edge = bus.start_btn & ~start_q;
      press      = bus.btn & ~btn_q;
      tgt_onehot = (bus.tgt != 4'd0) && ((bus.tgt & (bus.tgt - 4'd1)) == 4'd0);
      new_tgt    = tgt_onehot && (bus.tgt != tgt_q);
      hit_now    = 1'b0;
      miss_now   = 1'b0;
      open_mid   = win_open;
      if (open_mid && press != 4'd0) begin
         if (press == pending) hit_now = 1'b1;
         else                  miss_now = 1'b1;
         open_mid = 1'b0;
      end
      if (open_mid && win_cnt == '0) begin
         miss_now = 1'b1;
         open_mid = 1'b0;
      end
      open_end = open_mid;
      if (new_tgt) begin
         if (open_mid) miss_now = 1'b1;
         open_end = 1'b1;
      end
      if (bus.level_done && open_end) begin
         miss_now = 1'b1;
         open_end = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state           <= IDLE;
         start_q         <= 1'b0;
         btn_q           <= 4'd0;
         tgt_q           <= 4'd0;
         pending         <= 4'd0;
         win_open        <= 1'b0;
         win_cnt         <= '0;
         level_hits      <= '0;
         bus.level_sel   <= 2'd0;
         bus.level_start <= 1'b0;
         bus.score       <= '0;
         bus.misses      <= 8'd0;
         bus.hit_pulse   <= 1'b0;
         bus.miss_pulse  <= 1'b0;
         bus.game_over   <= 1'b0;
         bus.game_won    <= 1'b0;
      end else begin
         start_q         <= bus.start_btn;
         btn_q           <= bus.btn;
         tgt_q           <= bus.tgt;
         bus.level_start <= 1'b0;
         bus.hit_pulse   <= 1'b0;
         bus.miss_pulse  <= 1'b0;
         case (state)
            IDLE: begin
               if (start_edge) begin
                  bus.score       <= '0;
                  bus.misses      <= 8'd0;
                  bus.level_sel   <= 2'd0;
                  bus.level_start <= 1'b1;
                  state           <= LAUNCH;
               end
            end
            LAUNCH: begin
               level_hits <= '0;
               win_open   <= 1'b0;
               win_cnt    <= '0;
               state      <= PLAY;
            end
            PLAY: begin
               win_open <= open_end;
               // A freshly loaded window starts its countdown on the following tick.
               if (new_tgt) begin
                  pending <= bus.tgt;
                  win_cnt <= CNT_W'(HIT_WINDOW);
               end else if (open_mid && bus.tick) begin
                  win_cnt <= win_cnt - 1'b1;
               end
               if (hit_now) begin
                  if (bus.score != '1)  bus.score  <= bus.score + 1'b1;
                  if (level_hits != '1) level_hits <= level_hits + 1'b1;
                  bus.hit_pulse <= 1'b1;
               end
               if (miss_now) begin
                  if (bus.misses != 8'hFF) bus.misses <= bus.misses + 1'b1;
                  bus.miss_pulse <= 1'b1;
               end
               if (bus.level_done) state <= JUDGE;
            end
            JUDGE: begin
               if (level_hits >= SCORE_W'(PASS_SCORE)) begin
                  if (bus.level_sel == 2'(NUM_LEVELS - 1)) begin
                     bus.game_over <= 1'b1;
                     bus.game_won  <= 1'b1;
                     state         <= WON;
                  end else begin
                     state <= NEXT;
                  end
               end else begin
                  bus.game_over <= 1'b1;
                  state         <= LOST;
               end
            end
            NEXT: begin
               if (bus.level_sel < 2'(NUM_LEVELS - 1)) bus.level_sel <= bus.level_sel + 2'd1;
               bus.level_start <= 1'b1;
               state           <= LAUNCH;
            end
            WON, LOST: begin
               if (start_edge) begin
                  bus.game_over <= 1'b0;
                  bus.game_won  <= 1'b0;
                  state         <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule
